mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates one memory port between instruction fetch and data
//            access. Only one access is outstanding at a time. Fetch cannot be
//            starved by data beyond STARVE_LIMIT grants, and dLock holds off
//            fetch during atomic sequences.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            resetn,
    // fetch side
    input  logic            fReq,
    input  logic [XLEN-1:0] fAddr,
    input  logic            fAbort,
    output logic            fGnt,
    output logic            fValid,
    output logic [XLEN-1:0] fData,
    // data side
    input  logic            dReq,
    input  logic            dCmd,
    input  logic [XLEN-1:0] dAddr,
    input  logic [XLEN-1:0] dWData,
    input  logic            dLock,
    output logic            dGnt,
    output logic            dValid,
    output logic [XLEN-1:0] dRData,
    // memory port
    output logic            memEn,
    output logic            memCmd,
    output logic [XLEN-1:0] memAddr,
    output logic [XLEN-1:0] memWData,
    input  logic [XLEN-1:0] memRData,
    input  logic            memReady
);

    // The counter needs to hold STARVE_LIMIT itself, and is never narrower than 3 bits.
    localparam int c_CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_F = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = c_IDLE,
        S_BUSY_F = c_BUSY_F,
        S_BUSY_D = c_BUSY_D
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_starve;
    logic                 r_abort;
    logic                 r_memCmd;
    logic [XLEN-1:0]      r_memAddr;
    logic [XLEN-1:0]      r_memWData;
    logic                 r_fValid;
    logic                 r_dValid;
    logic [XLEN-1:0]      r_fData;
    logic [XLEN-1:0]      r_dRData;

    logic                 w_idle;
    logic                 w_fEligible;
    logic                 w_fGnt;
    logic                 w_dGnt;

    // Grants are gated by resetn so nothing is granted while reset is held.
    assign w_idle      = (r_state == S_IDLE) && resetn;
    // A fetch being redirected this cycle is not worth starting.
    assign w_fEligible = fReq && !fAbort;

    // Priority: atomic lock, then starved fetch, then data, then fetch.
    always_comb begin
        w_fGnt = 1'b0;
        w_dGnt = 1'b0;
        if (w_idle) begin
            if (dLock) begin
                w_dGnt = dReq;
            end else if ((r_starve == c_LIMIT) && w_fEligible) begin
                w_fGnt = 1'b1;
            end else if (dReq) begin
                w_dGnt = 1'b1;
            end else if (w_fEligible) begin
                w_fGnt = 1'b1;
            end
        end
    end

    // Access FSM: latch the winning request, hold it on the port, capture the response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_abort    <= 1'b0;
            r_memCmd   <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_fValid   <= 1'b0;
            r_dValid   <= 1'b0;
            r_fData    <= '0;
            r_dRData   <= '0;
        end else begin
            r_fValid <= 1'b0;
            r_dValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fGnt) begin
                        r_state   <= S_BUSY_F;
                        r_memCmd  <= 1'b0;
                        r_memAddr <= fAddr;
                        r_abort   <= fAbort;
                    end else if (w_dGnt) begin
                        r_state    <= S_BUSY_D;
                        r_memCmd   <= dCmd;
                        r_memAddr  <= dAddr;
                        r_memWData <= dWData;
                    end
                end
                S_BUSY_F: begin
                    if (memReady) begin
                        r_state  <= S_IDLE;
                        r_fData  <= memRData;
                        // A redirect seen at any point during the access discards the word.
                        r_fValid <= !(r_abort || fAbort);
                        r_abort  <= 1'b0;
                    end else if (fAbort) begin
                        r_abort <= 1'b1;
                    end
                end
                S_BUSY_D: begin
                    if (memReady) begin
                        r_state  <= S_IDLE;
                        r_dValid <= 1'b1;
                        if (!r_memCmd) begin
                            r_dRData <= memRData;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Starve counter: counts data wins over a waiting fetch, saturating at the limit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (w_fGnt) begin
            r_starve <= '0;
        end else if (w_idle && !fReq) begin
            r_starve <= '0;
        end else if (w_dGnt && fReq && (r_starve < c_LIMIT)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign fGnt     = w_fGnt;
    assign dGnt     = w_dGnt;
    assign memEn    = (r_state != S_IDLE);
    assign memCmd   = r_memCmd;
    assign memAddr  = r_memAddr;
    assign memWData = r_memWData;
    assign fValid   = r_fValid;
    assign dValid   = r_dValid;
    assign fData    = r_fData;
    assign dRData   = r_dRData;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Inputs change 1ns
//            after the rising edge; outputs are checked on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int XLEN = 32;

    logic            clock;
    logic            resetn;
    logic            fReq;
    logic [XLEN-1:0] fAddr;
    logic            fAbort;
    logic            fGnt;
    logic            fValid;
    logic [XLEN-1:0] fData;
    logic            dReq;
    logic            dCmd;
    logic [XLEN-1:0] dAddr;
    logic [XLEN-1:0] dWData;
    logic            dLock;
    logic            dGnt;
    logic            dValid;
    logic [XLEN-1:0] dRData;
    logic            memEn;
    logic            memCmd;
    logic [XLEN-1:0] memAddr;
    logic [XLEN-1:0] memWData;
    logic [XLEN-1:0] memRData;
    logic            memReady;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (4)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .fReq     (fReq),
        .fAddr    (fAddr),
        .fAbort   (fAbort),
        .fGnt     (fGnt),
        .fValid   (fValid),
        .fData    (fData),
        .dReq     (dReq),
        .dCmd     (dCmd),
        .dAddr    (dAddr),
        .dWData   (dWData),
        .dLock    (dLock),
        .dGnt     (dGnt),
        .dValid   (dValid),
        .dRData   (dRData),
        .memEn    (memEn),
        .memCmd   (memCmd),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memRData (memRData),
        .memReady (memReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // grant code: 2 = fetch, 1 = data, 0 = none
    function automatic logic [31:0] gnt();
        return 32'({fGnt, dGnt});
    endfunction

    initial begin
        logic [9:0] order;
        resetn = 1'b0; fReq = 1'b1; dReq = 1'b1; fAddr = 32'h0; fAbort = 1'b0;
        dCmd = 1'b0; dAddr = 32'h0; dWData = 32'h0; dLock = 1'b0;
        memRData = 32'h0; memReady = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_gnt",   gnt(), 32'd0);
        chk("rst_memEn", 32'(memEn), 32'd0);
        chk("rst_valid", 32'({fValid, dValid}), 32'd0);
        chk("rst_addr",  memAddr, 32'h0);
        @(posedge clock); #1;
        resetn = 1'b1; fReq = 1'b0; dReq = 1'b0;

        // ---------------- single fetch, zero wait ----------------
        @(posedge clock); #1;
        fReq = 1'b1; fAddr = 32'h100; memReady = 1'b1; memRData = 32'hA5A50100;
        @(negedge clock);
        chk("f0_gnt",   gnt(), 32'd2);
        chk("f0_memEn", 32'(memEn), 32'd0);
        @(posedge clock); #1;
        fReq = 1'b0;
        @(negedge clock);
        chk("f1_memEn",  32'(memEn), 32'd1);
        chk("f1_addr",   memAddr, 32'h100);
        chk("f1_cmd",    32'(memCmd), 32'd0);
        chk("f1_nogrant", gnt(), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("f2_valid", 32'(fValid), 32'd1);
        chk("f2_data",  fData, 32'hA5A50100);
        chk("f2_memEn", 32'(memEn), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("f3_valid", 32'(fValid), 32'd0);

        // ---------------- starvation limit ordering ----------------
        @(posedge clock); #1;
        fReq = 1'b1; dReq = 1'b1; dCmd = 1'b0; dAddr = 32'h500; fAddr = 32'h600;
        memRData = 32'h11112222;
        order = 10'b1000010000;   // bit i set -> access i is a fetch
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("order_%0d", i), gnt(), order[i] ? 32'd2 : 32'd1);
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("order_busy_%0d", i), 32'(memEn), 32'd1);
            @(posedge clock);
        end

        // ---------------- atomic lock holds off fetch ----------------
        #1;
        dLock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("lock_%0d", i), gnt(), 32'd1);
            @(posedge clock);
            @(posedge clock);
        end
        #1;
        dLock = 1'b0;
        @(negedge clock);
        chk("unlock_gnt", gnt(), 32'd2);
        @(posedge clock); #1;
        fReq = 1'b0; dReq = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("lock_rdata", dRData, 32'h11112222);

        // ---------------- wait states with fetch abort ----------------
        @(posedge clock); #1;
        fReq = 1'b1; fAddr = 32'h300; memReady = 1'b0; memRData = 32'h33333333;
        @(negedge clock);
        chk("ab_gnt", gnt(), 32'd2);
        @(posedge clock); #1;
        fReq = 1'b0; fAddr = 32'hFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) fAbort = 1'b1;
            if (i == 2) fAbort = 1'b0;
            if (i == 3) memReady = 1'b1;
            @(negedge clock);
            chk($sformatf("ab_memEn_%0d", i), 32'(memEn), 32'd1);
            chk($sformatf("ab_addr_%0d", i), memAddr, 32'h300);
            @(posedge clock); #1;
        end
        memReady = 1'b0;
        @(negedge clock);
        chk("ab_valid", 32'(fValid), 32'd0);
        chk("ab_idle",  32'(memEn), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("ab_valid2", 32'(fValid), 32'd0);

        // ---------------- write with wait states ----------------
        @(posedge clock); #1;
        dReq = 1'b1; dCmd = 1'b1; dAddr = 32'h2000; dWData = 32'hDEADBEEF;
        memRData = 32'h99999999;
        @(negedge clock);
        chk("wr_gnt", gnt(), 32'd1);
        @(posedge clock); #1;
        dReq = 1'b0; dCmd = 1'b0; dAddr = 32'h0; dWData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) memReady = 1'b1;
            @(negedge clock);
            chk($sformatf("wr_cmd_%0d", i),   32'(memCmd), 32'd1);
            chk($sformatf("wr_addr_%0d", i),  memAddr, 32'h2000);
            chk($sformatf("wr_wdata_%0d", i), memWData, 32'hDEADBEEF);
            chk($sformatf("wr_early_%0d", i), 32'(dValid), 32'd0);
            @(posedge clock); #1;
        end
        memReady = 1'b0;
        @(negedge clock);
        chk("wr_valid", 32'(dValid), 32'd1);
        chk("wr_rdata", dRData, 32'h11112222);
        chk("wr_idle",  32'(memEn), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("wr_valid_pulse", 32'(dValid), 32'd0);

        // ---------------- reset during a data access ----------------
        @(posedge clock); #1;
        dReq = 1'b1; dCmd = 1'b0; dAddr = 32'h40; memReady = 1'b0;
        @(negedge clock);
        chk("rs_gnt", gnt(), 32'd1);
        @(posedge clock); #1;
        dReq = 1'b0;
        @(negedge clock);
        chk("rs_busy", 32'(memEn), 32'd1);
        @(posedge clock); #1;
        resetn = 1'b0; memReady = 1'b1;
        #1;
        chk("rs_memEn", 32'(memEn), 32'd0);
        chk("rs_addr",  memAddr, 32'h0);
        chk("rs_rdata", dRData, 32'h0);
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk($sformatf("rs_novalid_%0d", i), 32'({dValid, memEn}), 32'd0);
            @(posedge clock); #1;
        end
        dReq = 1'b1; dAddr = 32'h44; memRData = 32'h44440000;
        @(negedge clock);
        chk("rs_regnt", gnt(), 32'd1);
        @(posedge clock); #1;
        dReq = 1'b0;
        @(negedge clock);
        chk("rs_readdr", memAddr, 32'h44);
        @(posedge clock); #1;
        @(negedge clock);
        chk("rs_revalid", 32'(dValid), 32'd1);
        chk("rs_redata",  dRData, 32'h44440000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
